// File: rtl/generador_pulsos.sv
// Pulse-train generator: N pulses of T_ON high / T_OFF low, outputs registered, first pulse on the edge that accepts inicio.
// Start requests are ignored while ocupado is high (no queuing); GEN_PULSOS_ABORTAR_EN adds the abortar input.
module generador_pulsos #(
    parameter int unsigned CICLOS_MS  = 50000,
    parameter int unsigned DUR_ON_MS  = 200,
    parameter int unsigned DUR_OFF_MS = 200,
    parameter int unsigned CUENTA_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inicio,
    input  logic [CUENTA_W-1:0] n_pulsos,
`ifdef GEN_PULSOS_ABORTAR_EN
    input  logic                abortar,
`endif
    output logic                salida,
    output logic                ocupado,
    output logic                fin
);

    localparam logic [31:0] T_ON  = 32'(DUR_ON_MS * CICLOS_MS);
    localparam logic [31:0] T_OFF = 32'(DUR_OFF_MS * CICLOS_MS);
    localparam logic [CUENTA_W-1:0] UNO = CUENTA_W'(1);

    typedef enum logic [1:0] {
        REPOSO,
        ENCENDIDO,
        APAGADO,
        FIN
    } estado_t;

    estado_t             estado_q;
    logic [31:0]         cnt_q;
    logic [CUENTA_W-1:0] restantes_q;
    logic                salida_q;
    logic                ocupado_q;
    logic                fin_q;

    logic abortar_act;
    logic fin_on;
    logic fin_off;

`ifdef GEN_PULSOS_ABORTAR_EN
    // Only meaningful during a train; ignored in REPOSO and FIN.
    assign abortar_act = abortar & ocupado_q;
`else
    assign abortar_act = 1'b0;
`endif

    assign fin_on  = (cnt_q == T_ON - 32'd1);
    assign fin_off = (cnt_q == T_OFF - 32'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q    <= REPOSO;
            cnt_q       <= '0;
            restantes_q <= '0;
            salida_q    <= 1'b0;
            ocupado_q   <= 1'b0;
            fin_q       <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            case (estado_q)
                REPOSO, FIN: begin
                    cnt_q <= '0;
                    if (inicio) begin
                        if (n_pulsos != '0) begin
                            restantes_q <= n_pulsos;
                            estado_q    <= ENCENDIDO;
                            salida_q    <= 1'b1;
                            ocupado_q   <= 1'b1;
                        end else begin
                            estado_q <= FIN;
                            fin_q    <= 1'b1;
                        end
                    end else begin
                        estado_q <= REPOSO;
                    end
                end
                ENCENDIDO: begin
                    if (abortar_act) begin
                        estado_q    <= FIN;
                        cnt_q       <= '0;
                        restantes_q <= '0;
                        salida_q    <= 1'b0;
                        ocupado_q   <= 1'b0;
                        fin_q       <= 1'b1;
                    end else if (fin_on) begin
                        estado_q <= APAGADO;
                        cnt_q    <= '0;
                        salida_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                APAGADO: begin
                    if (abortar_act) begin
                        estado_q    <= FIN;
                        cnt_q       <= '0;
                        restantes_q <= '0;
                        salida_q    <= 1'b0;
                        ocupado_q   <= 1'b0;
                        fin_q       <= 1'b1;
                    end else if (fin_off) begin
                        cnt_q <= '0;
                        // The last pulse also gets its full low gap before fin.
                        if (restantes_q > UNO) begin
                            restantes_q <= restantes_q - UNO;
                            estado_q    <= ENCENDIDO;
                            salida_q    <= 1'b1;
                        end else begin
                            restantes_q <= '0;
                            estado_q    <= FIN;
                            ocupado_q   <= 1'b0;
                            fin_q       <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    estado_q    <= REPOSO;
                    cnt_q       <= '0;
                    restantes_q <= '0;
                    salida_q    <= 1'b0;
                    ocupado_q   <= 1'b0;
                end
            endcase
        end
    end

    assign salida  = salida_q;
    assign ocupado = ocupado_q;
    assign fin     = fin_q;

endmodule

// File: tb/tb_generador_pulsos.sv
// Scoreboard bench: stimulus pushes expected output events (kind, edge number); a negedge monitor pops and compares.
module tb_generador_pulsos;

    localparam int CUENTA_W = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                inicio;
    logic [CUENTA_W-1:0] n_pulsos;
    logic                salida;
    logic                ocupado;
    logic                fin;
`ifdef GEN_PULSOS_ABORTAR_EN
    logic                abortar;
`endif

    generador_pulsos #(
        .CICLOS_MS (10),
        .DUR_ON_MS (2),
        .DUR_OFF_MS(3),
        .CUENTA_W  (CUENTA_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .inicio  (inicio),
        .n_pulsos(n_pulsos),
`ifdef GEN_PULSOS_ABORTAR_EN
        .abortar (abortar),
`endif
        .salida  (salida),
        .ocupado (ocupado),
        .fin     (fin)
    );

    always #5 clk = ~clk;

    typedef enum {EV_OCU_UP, EV_SAL_UP, EV_SAL_DN, EV_OCU_DN, EV_FIN} ev_t;
    typedef struct {
        ev_t kind;
        int  cyc;
    } evento_t;

    evento_t esperado[$];
    int      cyc = 0;
    int      checks = 0;
    int      failures = 0;
    logic    p_sal = 1'b0;
    logic    p_ocu = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input ev_t kind, input int c);
        evento_t e;
        e.kind = kind;
        e.cyc  = c;
        esperado.push_back(e);
    endtask

    task automatic got(input ev_t kind);
        evento_t e;
        checks++;
        if (esperado.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got %s at edge %0d, expected none", kind.name(), cyc);
        end else begin
            e = esperado.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
                failures++;
                $display("FAIL event_order: got %s at edge %0d, expected %s at edge %0d",
                         kind.name(), cyc, e.kind.name(), e.cyc);
            end
        end
    endtask

    // Same-edge events are detected in this fixed order; pushes follow it too.
    always @(negedge clk) begin
        if (ocupado === 1'b1 && !p_ocu) got(EV_OCU_UP);
        if (salida === 1'b1 && !p_sal) got(EV_SAL_UP);
        if (salida !== 1'b1 && p_sal) got(EV_SAL_DN);
        if (ocupado !== 1'b1 && p_ocu) got(EV_OCU_DN);
        if (fin === 1'b1) got(EV_FIN);
        p_sal = (salida === 1'b1);
        p_ocu = (ocupado === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hasta(input int objetivo);
        while (cyc < objetivo) tick(1);
    endtask

    task automatic check_bit(input string nombre, input logic actual, input logic req);
        checks++;
        if (actual !== req) begin
            failures++;
            $display("FAIL %s: got %b, expected %b", nombre, actual, req);
        end
    endtask

    // Pushes the full event list for an uninterrupted n-pulse train accepted at edge k+1.
    task automatic push_tren(input int k, input int n);
        push(EV_OCU_UP, k + 1);
        push(EV_SAL_UP, k + 1);
        for (int i = 0; i < n; i++) begin
            if (i > 0) push(EV_SAL_UP, k + 1 + i * 50);
            push(EV_SAL_DN, k + 21 + i * 50);
        end
        push(EV_OCU_DN, k + 1 + n * 50);
        push(EV_FIN, k + 1 + n * 50);
    endtask

    initial begin
        int k;
        rst_n    = 1'b0;
        inicio   = 1'b0;
        n_pulsos = '0;
`ifdef GEN_PULSOS_ABORTAR_EN
        abortar  = 1'b0;
`endif
        tick(3);
        check_bit("reset_salida", salida, 1'b0);
        check_bit("reset_ocupado", ocupado, 1'b0);
        check_bit("reset_fin", fin, 1'b0);
        rst_n = 1'b1;
        tick(2);

        // Single 3-pulse train.
        k = cyc;
        inicio   = 1'b1;
        n_pulsos = 4'd3;
        push_tren(k, 3);
        tick(1);
        inicio = 1'b0;
        hasta(k + 160);

        // Zero count: fin only.
        k = cyc;
        inicio   = 1'b1;
        n_pulsos = 4'd0;
        push(EV_FIN, k + 1);
        tick(1);
        inicio = 1'b0;
        hasta(k + 10);

        // 2-pulse train, stray start mid-train, then a start held across FIN.
        k = cyc;
        inicio   = 1'b1;
        n_pulsos = 4'd2;
        push_tren(k, 2);
        tick(1);
        inicio = 1'b0;
        hasta(k + 40);
        inicio   = 1'b1;
        n_pulsos = 4'd5;
        tick(1);
        inicio = 1'b0;
        hasta(k + 100);
        inicio   = 1'b1;
        n_pulsos = 4'd1;
        push(EV_OCU_UP, k + 102);
        push(EV_SAL_UP, k + 102);
        push(EV_SAL_DN, k + 122);
        push(EV_OCU_DN, k + 152);
        push(EV_FIN, k + 152);
        hasta(k + 102);
        inicio = 1'b0;
        hasta(k + 165);

        // Reset in the middle of the first pulse: no fin afterwards.
        k = cyc;
        inicio   = 1'b1;
        n_pulsos = 4'd3;
        push(EV_OCU_UP, k + 1);
        push(EV_SAL_UP, k + 1);
        tick(1);
        inicio = 1'b0;
        hasta(k + 10);
        rst_n = 1'b0;
        push(EV_SAL_DN, k + 11);
        push(EV_OCU_DN, k + 11);
        tick(3);
        rst_n = 1'b1;
        hasta(k + 200);

`ifdef GEN_PULSOS_ABORTAR_EN
        // Abort during the first off gap of a 4-pulse train.
        k = cyc;
        inicio   = 1'b1;
        n_pulsos = 4'd4;
        push(EV_OCU_UP, k + 1);
        push(EV_SAL_UP, k + 1);
        push(EV_SAL_DN, k + 21);
        push(EV_OCU_DN, k + 26);
        push(EV_FIN, k + 26);
        tick(1);
        inicio = 1'b0;
        hasta(k + 25);
        abortar = 1'b1;
        tick(1);
        abortar = 1'b0;
        hasta(k + 120);

        // Abort while idle does nothing.
        abortar = 1'b1;
        tick(3);
        abortar = 1'b0;
        tick(10);
`endif

        tick(2);
        checks++;
        if (esperado.size() != 0) begin
            failures++;
            $display("FAIL missing_events: %0d events never seen, expected 0", esperado.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
